// File: rtl/wb_pipe_pkg.sv
// Writeback stage shared definitions.
// Data width default and load size/sign encodings.
package wb_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_op_e;

endpackage

// File: rtl/wb_pipe_load_extend.sv
// Load data extension for the writeback stage.
// Picks the low-order slice of the loaded word and sign/zero extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] memData,
    output logic [XLEN-1:0] extData
);

    load_op_e op;

    assign op = load_op_e'(funct3);

    // Extend the addressed slice; encoding 3'b111 behaves like a full load
    always_comb begin
        extData = memData;
        case (op)
            LB:  extData = {{(XLEN-8){memData[7]}}, memData[7:0]};
            LH:  extData = {{(XLEN-16){memData[15]}}, memData[15:0]};
            LW:  extData = {{(XLEN-32){memData[31]}}, memData[31:0]};
            LD:  extData = memData;
            LBU: extData = {{(XLEN-8){1'b0}}, memData[7:0]};
            LHU: extData = {{(XLEN-16){1'b0}}, memData[15:0]};
            LWU: extData = {{(XLEN-32){1'b0}}, memData[31:0]};
            default: extData = memData;
        endcase
    end

endmodule

// File: rtl/wb_pipe.sv
// Writeback pipeline stage: stage register, result select,
// x0 write suppression, bypass register and retire counter.
module wb_pipe
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       in_rd,
    input  logic             in_RegWrite,
    input  logic             in_MemToReg,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_aluResult,
    input  logic [XLEN-1:0]  in_memData,
    output logic [4:0]       writeAddr,
    output logic [XLEN-1:0]  writeData,
    output logic             RegWrite,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retired
);

    logic             valid_q,     valid_d;
    logic [4:0]       rd_q,        rd_d;
    logic             regwrite_q,  regwrite_d;
    logic             memtoreg_q,  memtoreg_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [XLEN-1:0]  alu_q,       alu_d;
    logic [XLEN-1:0]  mem_q,       mem_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [4:0]       fwd_addr_q,  fwd_addr_d;
    logic [XLEN-1:0]  fwd_data_q,  fwd_data_d;
    logic [CNT_W-1:0] retired_q,   retired_d;
    logic [XLEN-1:0]  load_data;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3  (funct3_q),
        .memData (mem_q),
        .extData (load_data)
    );

    assign writeAddr = rd_q;
    assign writeData = memtoreg_q ? load_data : alu_q;
    assign RegWrite  = valid_q & regwrite_q & (rd_q != 5'd0);
    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;
    assign retired   = retired_q;

    // Stage register: load when not stalled, flush kills the valid bit
    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        funct3_d   = funct3_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        if (!stall) begin
            valid_d    = in_valid;
            rd_d       = in_rd;
            regwrite_d = in_RegWrite;
            memtoreg_d = in_MemToReg;
            funct3_d   = in_funct3;
            alu_d      = in_aluResult;
            mem_d      = in_memData;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Bypass captures each committed write; counter bumps when an instruction leaves
    always_comb begin
        fwd_valid_d = RegWrite;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        retired_d   = retired_q;
        if (RegWrite) begin
            fwd_addr_d = writeAddr;
            fwd_data_d = writeData;
        end
        if (valid_q && !stall) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State update with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            funct3_q    <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            retired_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            mem_q       <= mem_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            retired_q   <= retired_d;
        end
    end

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe.
// Expected writebacks are queued at drive time and consumed per clock.
module tb_wb_pipe;

    localparam int XL = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [4:0]    in_rd = '0;
    logic          in_RegWrite = 1'b0;
    logic          in_MemToReg = 1'b0;
    logic [2:0]    in_funct3 = '0;
    logic [XL-1:0] in_aluResult = '0;
    logic [XL-1:0] in_memData = '0;
    logic [4:0]    writeAddr;
    logic [XL-1:0] writeData;
    logic          RegWrite;
    logic          fwd_valid;
    logic [4:0]    fwd_addr;
    logic [XL-1:0] fwd_data;
    logic [CW-1:0] retired;

    wb_pipe #(.XLEN(XL), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .in_rd        (in_rd),
        .in_RegWrite  (in_RegWrite),
        .in_MemToReg  (in_MemToReg),
        .in_funct3    (in_funct3),
        .in_aluResult (in_aluResult),
        .in_memData   (in_memData),
        .writeAddr    (writeAddr),
        .writeData    (writeData),
        .RegWrite     (RegWrite),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [4:0]    a;
        logic [XL-1:0] d;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    logic          efv;
    logic [4:0]    efa;
    logic [XL-1:0] efd;
    logic [CW-1:0] eret;
    int            n_pass = 0;
    int            n_tot = 0;

    function automatic logic [XL-1:0] ref_ext(input logic [2:0] f, input logic [XL-1:0] m);
        case (f)
            3'd0: return {{56{m[7]}}, m[7:0]};
            3'd1: return {{48{m[15]}}, m[15:0]};
            3'd2: return {{32{m[31]}}, m[31:0]};
            3'd4: return {56'd0, m[7:0]};
            3'd5: return {48'd0, m[15:0]};
            3'd6: return {32'd0, m[31:0]};
            default: return m;
        endcase
    endfunction

    task automatic model_reset();
        cur = '0;
        efv = 1'b0;
        efa = '0;
        efd = '0;
        eret = '0;
        sb.delete();
    endtask

    task automatic put(input logic v, input logic [4:0] rd, input logic rw,
                       input logic m2r, input logic [2:0] f3,
                       input logic [XL-1:0] alu, input logic [XL-1:0] mem,
                       input logic st, input logic fl);
        exp_t e;
        in_valid = v;
        in_rd = rd;
        in_RegWrite = rw;
        in_MemToReg = m2r;
        in_funct3 = f3;
        in_aluResult = alu;
        in_memData = mem;
        stall = st;
        flush = fl;
        e.v = v;
        e.we = v && rw && (rd != 5'd0);
        e.a = rd;
        e.d = m2r ? ref_ext(f3, mem) : alu;
        if (!st) sb.push_back(e);
    endtask

    task automatic idle();
        put(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        exp_t nx;
        @(posedge clk);
        if (cur.v && !stall) eret = eret + 1;
        efv = cur.we;
        if (cur.we) begin
            efa = cur.a;
            efd = cur.d;
        end
        nx = cur;
        if (!stall) begin
            n_tot++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: queue empty, required one entry");
            end else begin
                nx = sb.pop_front();
                n_pass++;
            end
        end
        if (flush) begin
            nx.v = 1'b0;
            nx.we = 1'b0;
        end
        cur = nx;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_rd = 5'd9;
        in_RegWrite = 1'b1;
        in_aluResult = 64'h55;
        repeat (2) @(negedge clk);
        n_tot++;
        if ({RegWrite, writeAddr, writeData, fwd_valid, fwd_addr, fwd_data, retired} !== '0)
            $display("FAIL reset_outputs: got we=%0b a=%0d d=%h fv=%0b fa=%0d fd=%h ret=%0d, required all 0",
                     RegWrite, writeAddr, writeData, fwd_valid, fwd_addr, fwd_data, retired);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        idle();
        tick();
        n_tot++;
        if (RegWrite !== 1'b0 || retired !== '0)
            $display("FAIL reset_idle: got we=%0b ret=%0d, required 0/0", RegWrite, retired);
        else n_pass++;
    endtask

    task automatic test_alu();
        put(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 64'h1234, '0, 1'b0, 1'b0);
        tick();
        n_tot++;
        if (RegWrite !== 1'b1 || writeAddr !== 5'd5 || writeData !== 64'h1234)
            $display("FAIL alu_wb: got we=%0b a=%0d d=%h, required 1/5/1234",
                     RegWrite, writeAddr, writeData);
        else n_pass++;
        idle();
        tick();
        n_tot++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 5'd5 || fwd_data !== 64'h1234)
            $display("FAIL alu_fwd: got fv=%0b fa=%0d fd=%h, required 1/5/1234",
                     fwd_valid, fwd_addr, fwd_data);
        else n_pass++;
        n_tot++;
        if (retired !== eret)
            $display("FAIL alu_retired: got %0d, required %0d", retired, eret);
        else n_pass++;
    endtask

    task automatic test_loads();
        logic [2:0]    f3s [6];
        logic [XL-1:0] exps [6];
        f3s = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6};
        exps = '{64'hFFFFFFFF_FFFFFF80, 64'h80, 64'hFFFFFFFF_FFFFFF80,
                 64'hFF80, 64'hFFFFFFFF_8000FF80, 64'h8000FF80};
        for (int i = 0; i < 6; i++) begin
            put(1'b1, 5'd10, 1'b1, 1'b1, f3s[i], 64'hBAD, 64'h00000000_8000FF80, 1'b0, 1'b0);
            tick();
            n_tot++;
            if (RegWrite !== 1'b1 || writeData !== exps[i] || writeData !== cur.d)
                $display("FAIL load_f3_%0d: got we=%0b d=%h, required 1/%h",
                         f3s[i], RegWrite, writeData, exps[i]);
            else n_pass++;
        end
        for (int i = 3; i < 8; i += 4) begin
            put(1'b1, 5'd11, 1'b1, 1'b1, 3'(i), '0, 64'h8123_4567_89AB_CDEF, 1'b0, 1'b0);
            tick();
            n_tot++;
            if (writeData !== 64'h8123_4567_89AB_CDEF)
                $display("FAIL load_full_%0d: got %h, required 8123456789abcdef", i, writeData);
            else n_pass++;
        end
    endtask

    task automatic test_x0();
        logic [CW-1:0] r0;
        put(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 64'hDEAD, '0, 1'b0, 1'b0);
        tick();
        r0 = retired;
        n_tot++;
        if (RegWrite !== 1'b0)
            $display("FAIL x0_we: got %0b, required 0", RegWrite);
        else n_pass++;
        idle();
        tick();
        n_tot++;
        if (fwd_valid !== 1'b0 || retired !== r0 + 1 || retired !== eret)
            $display("FAIL x0_fwd_ret: got fv=%0b ret=%0d, required 0/%0d",
                     fwd_valid, retired, r0 + 1);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [CW-1:0] r1;
        put(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 64'hABCD, '0, 1'b0, 1'b0);
        tick();
        r1 = retired;
        for (int c = 0; c < 4; c++) begin
            n_tot++;
            if (RegWrite !== 1'b1 || writeAddr !== 5'd9 || writeData !== 64'hABCD)
                $display("FAIL stall_hold_%0d: got we=%0b a=%0d d=%h, required 1/9/abcd",
                         c, RegWrite, writeAddr, writeData);
            else n_pass++;
            if (c < 3) begin
                put(1'b1, 5'd20, 1'b1, 1'b0, 3'd0, 64'h9999, '0, 1'b1, 1'b0);
                tick();
            end
        end
        n_tot++;
        if (retired !== r1 || fwd_valid !== 1'b1 || fwd_data !== 64'hABCD)
            $display("FAIL stall_ret: got ret=%0d fv=%0b fd=%h, required %0d/1/abcd",
                     retired, fwd_valid, fwd_data, r1);
        else n_pass++;
        idle();
        tick();
        n_tot++;
        if (retired !== r1 + 1 || RegWrite !== 1'b0)
            $display("FAIL stall_release: got ret=%0d we=%0b, required %0d/0",
                     retired, RegWrite, r1 + 1);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [CW-1:0] r;
        logic [4:0]    fa;
        put(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 64'h77, '0, 1'b0, 1'b1);
        tick();
        fa = fwd_addr;
        n_tot++;
        if (RegWrite !== 1'b0)
            $display("FAIL flush_we: got %0b, required 0", RegWrite);
        else n_pass++;
        idle();
        tick();
        n_tot++;
        if (fwd_valid !== 1'b0 || fwd_addr !== fa || fwd_addr !== efa)
            $display("FAIL flush_fwd: got fv=%0b fa=%0d, required 0/%0d", fwd_valid, fwd_addr, fa);
        else n_pass++;
        put(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 64'h33, '0, 1'b0, 1'b0);
        tick();
        r = retired;
        put(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 64'h44, '0, 1'b1, 1'b1);
        tick();
        n_tot++;
        if (RegWrite !== 1'b0 || retired !== r)
            $display("FAIL flush_stall: got we=%0b ret=%0d, required 0/%0d", RegWrite, retired, r);
        else n_pass++;
        put(1'b1, 5'd6, 1'b1, 1'b0, 3'd0, 64'h66, '0, 1'b0, 0);
        tick();
        put(1'b1, 5'd8, 1'b1, 1'b0, 3'd0, 64'h88, '0, 1'b0, 1'b1);
        tick();
        n_tot++;
        if (retired !== r + 1 || retired !== eret || RegWrite !== 1'b0)
            $display("FAIL flush_retire: got ret=%0d we=%0b, required %0d/0", retired, RegWrite, r + 1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        put(1'b1, 5'd12, 1'b1, 1'b0, 3'd0, 64'hC0DE, '0, 1'b0, 1'b0);
        tick();
        put(1'b1, 5'd13, 1'b1, 1'b0, 3'd0, 64'hF00D, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tot++;
        if ({RegWrite, writeAddr, writeData, fwd_valid, fwd_addr, fwd_data, retired} !== '0)
            $display("FAIL async_reset: got we=%0b a=%0d d=%h fv=%0b fa=%0d fd=%h ret=%0d, required all 0",
                     RegWrite, writeAddr, writeData, fwd_valid, fwd_addr, fwd_data, retired);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        put(1'b1, 5'd14, 1'b1, 1'b0, 3'd0, 64'h1414, '0, 1'b0, 1'b0);
        tick();
        n_tot++;
        if (RegWrite !== 1'b1 || writeAddr !== 5'd14 || writeData !== 64'h1414 || retired !== '0)
            $display("FAIL post_reset: got we=%0b a=%0d d=%h ret=%0d, required 1/14/1414/0",
                     RegWrite, writeAddr, writeData, retired);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            put(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));
            tick();
            n_tot++;
            if (RegWrite !== cur.we || (!flush && (writeAddr !== cur.a || writeData !== cur.d)))
                $display("FAIL b2b_wb_%0d: got we=%0b a=%0d d=%h, required %0b/%0d/%h",
                         i, RegWrite, writeAddr, writeData, cur.we, cur.a, cur.d);
            else n_pass++;
            n_tot++;
            if (fwd_valid !== efv || fwd_addr !== efa || fwd_data !== efd || retired !== eret)
                $display("FAIL b2b_fwd_%0d: got fv=%0b fa=%0d fd=%h ret=%0d, required %0b/%0d/%h/%0d",
                         i, fwd_valid, fwd_addr, fwd_data, retired, efv, efa, efd, eret);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu();
        test_loads();
        test_x0();
        test_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  MEM stage presents an instruction.
REQ-006 SHALL have port stall  input  1  hold the stage register.
REQ-007 SHALL have port flush  input  1  invalidate the stage register.
REQ-008 SHALL have port in_rd  input  5  destination register.
REQ-009 SHALL have port in_RegWrite  input  1  instruction writes rd.
REQ-010 SHALL have port in_MemToReg  input  1  result taken from load data rather than ALU.
REQ-011 SHALL have port in_funct3  input  3  load size/sign code.
REQ-012 SHALL have port in_aluResult  input  XLEN  ALU result.
REQ-013 SHALL have port in_memData  input  XLEN  raw doubleword read from data memory.
REQ-014 SHALL have port writeAddr  output  5  register file write address.
REQ-015 SHALL have port writeData  output  XLEN  register file write data.
REQ-016 SHALL have port RegWrite  output  1  register file write enable.
REQ-017 SHALL have port fwd_valid  output  1  bypass entry valid.
REQ-018 SHALL have port fwd_addr  output  5  bypass register number.
REQ-019 SHALL have port fwd_data  output  XLEN  bypass value (last committed write).
REQ-020 SHALL have port retired  output  CNT_W  count of instructions that left the stage.

Function
REQ-021 Stage register (valid_q, rd, RegWrite, MemToReg, funct3, aluResult, memData) SHALL load from inputs on each rising edge with stall=0 and flush=0.
REQ-022 stall=1, flush=0: stage register SHALL hold all fields.
REQ-023 flush=1: valid_q SHALL clear next edge regardless of stall; other fields don't-care.
REQ-024 writeAddr SHALL equal stored rd; writeData SHALL be combinational from stage register (zero extra latency; input-to-output latency 1 cycle).
REQ-025 RegWrite SHALL equal valid_q AND stored RegWrite AND (stored rd != 0); writes to x0 never asserted.
REQ-026 writeData SHALL be aluResult when MemToReg=0, else load-extended memData.
REQ-027 Load extension from memData low bits: 000 sign-extend [7:0]; 001 sign-extend [15:0]; 010 sign-extend [31:0]; 011 full [63:0]; 100 zero-extend [7:0]; 101 zero-extend [15:0]; 110 zero-extend [31:0]; 111 full [63:0].
REQ-028 During stall, RegWrite SHALL remain asserted for the held instruction (idempotent rewrite of identical data).
REQ-029 Bypass register SHALL capture writeAddr/writeData on each edge where RegWrite=1; fwd_valid SHALL be registered RegWrite (asserted exactly the cycle after each write cycle).
REQ-030 retired SHALL increment by 1 on each edge where valid_q=1 and stall=0 (instruction leaves), including flush-coincident edges; wraps modulo 2^CNT_W.
REQ-031 Flush and stall with valid_q=1 on same edge SHALL not increment retired.
REQ-032 Instructions with in_RegWrite=0 (stores, branches) SHALL still count in retired.

Reset
REQ-033 rst_n low SHALL immediately clear valid_q, all stage fields, bypass register, fwd_valid and retired to 0, independent of clk.
REQ-034 During and right after reset: RegWrite=0, writeAddr=0, writeData=0, fwd_valid=0, fwd_addr=0, fwd_data=0, retired=0.
REQ-035 Reset mid-stall SHALL discard the held instruction; first post-reset edge captures inputs normally.

Structure
REQ-036 Shared package wb_pkg SHALL hold XLEN default and the load funct3 encoding enum (LB, LH, LW, LD, LBU, LHU, LWU).
REQ-037 Load extension SHALL be a separate combinational sub-module load_extend (inputs funct3, memData; output extended XLEN value).

Verification
REQ-038 ALU writeback: in_valid=1, rd=5, RegWrite=1, MemToReg=0, alu=0x1234 -> next cycle RegWrite=1, writeAddr=5, writeData=0x1234; following cycle fwd_valid=1, fwd_addr=5, fwd_data=0x1234.
REQ-039 Loads: memData=0x00000000_8000FF80, MemToReg=1, funct3=000/100/001/101/010/110 -> writeData=0xFFFFFFFF_FFFFFF80 / 0x80 / 0xFFFFFFFF_FFFFFF80 / 0xFF80 / 0xFFFFFFFF_8000FF80 / 0x8000FF80.
REQ-040 x0 suppression: rd=0, RegWrite=1, alu=0xDEAD -> RegWrite=0, fwd_valid=0 next cycle; retired increments by 1.
REQ-041 Stall 3 cycles then release: RegWrite held 1 with same addr/data for 4 cycles; retired increments exactly once.
REQ-042 flush=1 with valid instruction, rd=7 -> RegWrite=0 next cycle, no bypass update; rst_n pulsed low asynchronously mid-stream -> all outputs 0 immediately, retired=0.
